fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares one synchronous FIFO's write side among NUM_REQ requesters. It sits between the requester agents and the FIFO, drives the FIFO write port from registered outputs, and never lets a write reach a full FIFO. It also checks every issued write against the FIFO's `wr_ack` and flags lost writes.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned REQ_IDX_W   = $clog2(NUM_REQ_DEF);
  localparam int unsigned DROP_CNT_W  = 8;
  localparam int unsigned GRANT_CNT_W = 16;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  // Saturating increment for the drop counter.
  function automatic logic [DROP_CNT_W-1:0] drop_cnt_inc(input logic [DROP_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   sel,
  output logic               any
);

  always_comb begin
    int   idx;
    logic found;
    sel   = '0;
    any   = |valid;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (int'(ptr) + k) % int'(NUM_REQ);
      if (!found && valid[IDX_W'(idx)]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; checks wr_ack for lost writes.
// Optional per-requester grant counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 arb_en,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]                fifo_data_in,
  input  logic                                 fifo_full,
  input  logic                                 fifo_almostfull,
  input  logic                                 fifo_wr_ack,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ-1:0][GRANT_CNT_W-1:0]  grant_cnt,
`endif
  output logic                                 err_drop,
  output logic [DROP_CNT_W-1:0]                drop_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || FIFO_DEPTH < 2) begin : g_cfg_err
    $error("fifo_wr_arbiter: unsupported NUM_REQ/FIFO_DEPTH");
  end

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel;
  logic             any_valid;
  logic             issue_ok;
  logic             xfer;
  logic             ack_pending;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .sel   (sel),
    .any   (any_valid)
  );

  // Almostfull with a write already registered means the FIFO fills on the next edge.
  assign issue_ok = arb_en & ~fifo_full & ~(fifo_almostfull & fifo_wr_en);
  assign xfer     = rst_n & issue_ok & any_valid;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[sel] = 1'b1;
  end

  // Write port and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      rr_ptr       <= '0;
    end else if (xfer) begin
      fifo_wr_en   <= 1'b1;
      fifo_data_in <= req_data[sel];
      rr_ptr       <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
    end else begin
      fifo_wr_en   <= 1'b0;
    end
  end

  // Every issued write must be acknowledged the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pending <= 1'b0;
      err_drop    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      ack_pending <= fifo_wr_en;
      if (ack_pending && !fifo_wr_ack) begin
        err_drop <= 1'b1;
        drop_cnt <= drop_cnt_inc(drop_cnt);
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_stats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grant_cnt[i] <= '0;
      end else if (xfer && (sel == IDX_W'(i)) && !(&grant_cnt[i])) begin
        grant_cnt[i] <= grant_cnt[i] + GRANT_CNT_W'(1);
      end
    end
  end
`endif

endmodule
